serial_add_ctrl: RTL and testbench

Byte-serial multi-precision add/subtract controller. Accepts two NBYTES-wide operands over a valid/ready handshake and sequences them through a single 8-bit ripple-carry adder slice, least-significant byte first, one byte per clock. The byte carry-out is registered and chained into the next byte. It sits between the operand source (register file or bus master) and the result consumer. It lets wide additions reuse one 8-bit adder instead of a full-width one.

---
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Byte-serial multi-precision add/subtract controller: one 8-bit adder slice
// is reused LSB-first, with the byte carry registered between passes.
module serial_add_ctrl #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES,
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              c_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              sub_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [7:0]        a_byte;
    logic [7:0]        b_byte;
    logic [7:0]        low7;
    logic [8:0]        full;
    logic              byte_ovf;
    logic              last_byte;

    // Adder slice: low7 exposes the carry into bit 7 for signed overflow.
    always_comb begin
        a_byte    = a_q[idx_q*8 +: 8];
        b_byte    = b_q[idx_q*8 +: 8] ^ {8{sub_q}};
        low7      = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'd0, c_q};
        full      = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, c_q};
        byte_ovf  = low7[7] ^ full[8];
        last_byte = (idx_q == IDXW'(NBYTES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand registers are left out of reset; they are always
            // loaded at accept before being read, so resetting them buys nothing.
            state_q     <= IDLE;
            idx_q       <= '0;
            c_q         <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        sub_q      <= sub;
                        c_q        <= cin ^ sub;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*8 +: 8] <= full[7:0];
                    c_q                 <= full[8];
                    if (last_byte) begin
                        cout_q      <= full[8];
                        ovf_q       <= byte_ovf;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (NBYTES=4): hand-computed results,
// exact latency, backpressure hold and mid-operation reset.
module tb_serial_add_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    serial_add_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request while IDLE and let one edge accept it; returns #1 after.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sv, input logic cv, input string tag);
        a = av; b = bv; sub = sv; cin = cv; in_valid = 1'b1;
        check({tag, " in_ready before accept"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = ~bv; sub = ~sv; cin = ~cv;
        check({tag, " in_ready after accept"}, {63'd0, in_ready}, 64'd0);
        check({tag, " out_valid after accept"}, {63'd0, out_valid}, 64'd0);
    endtask

    // Step NBYTES edges, checking out_valid rises exactly on the last one,
    // then check the result and (if out_ready) the return to IDLE.
    task automatic wait_result(input logic [W-1:0] es, input logic ec, input logic eo,
                               input string tag);
        for (int k = 1; k <= NBYTES; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s out_valid at cycle %0d", tag, k), {63'd0, out_valid},
                  {63'd0, (k == NBYTES)});
        end
        check({tag, " sum"},  {32'd0, sum},  {32'd0, es});
        check({tag, " cout"}, {63'd0, cout}, {63'd0, ec});
        check({tag, " ovf"},  {63'd0, ovf},  {63'd0, eo});
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, " in_ready after handshake"}, {63'd0, in_ready}, 64'd1);
            check({tag, " out_valid after handshake"}, {63'd0, out_valid}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready",  {63'd0, in_ready},  64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset sum",       {32'd0, sum},       64'd0);
        check("reset cout",      {63'd0, cout},      64'd0);
        check("reset ovf",       {63'd0, ovf},       64'd0);

        // Carry across a byte boundary.
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "carry");
        wait_result(32'h0000_0100, 1'b0, 1'b0, "carry");
        // Full ripple from carry-in.
        start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, "ripple");
        wait_result(32'h0000_0000, 1'b1, 1'b0, "ripple");
        // Positive signed overflow.
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf_add");
        wait_result(32'h8000_0000, 1'b0, 1'b1, "ovf_add");
        // Subtract producing a borrow.
        start_op(32'd5, 32'd7, 1'b1, 1'b0, "sub_borrow");
        wait_result(32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        // Subtract with borrow-in, no borrow out.
        start_op(32'd7, 32'd5, 1'b1, 1'b1, "sub_bin");
        wait_result(32'h0000_0001, 1'b1, 1'b0, "sub_bin");
        // Negative signed overflow on subtract.
        start_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "ovf_sub");
        wait_result(32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_sub");

        // Backpressure: result held for 10 cycles while inputs churn.
        out_ready = 1'b0;
        start_op(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, "bp");
        wait_result(32'h0001_FFFF, 1'b0, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom; in_valid = i[0]; sub = i[1]; cin = i[2];
            @(posedge clk); #1;
            check($sformatf("bp hold sum %0d", i), {32'd0, sum}, 64'h0001_FFFF);
            check($sformatf("bp hold flags %0d", i), {60'd0, out_valid, in_ready, cout, ovf},
                  64'b1000);
        end
        a = 32'h0000_0003; b = 32'h0000_0004; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release in_ready",  {63'd0, in_ready},  64'd1);
        check("bp release out_valid", {63'd0, out_valid}, 64'd0);
        start_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, "bp next");
        wait_result(32'h0000_0007, 1'b0, 1'b0, "bp next");

        // Reset during the second RUN cycle discards the operation.
        start_op(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 1'b0, "rst_mid");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid sum",       {32'd0, sum},       64'd0);
        check("rst_mid in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_mid cout/ovf",  {62'd0, cout, ovf}, 64'd0);
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "after_rst");
        wait_result(32'h2345_6789, 1'b0, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
